mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 61 ++++++
 tb/tb_mem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: loads a table from a streamed file (word beats then an end marker),
// zero-pads a short file, then serves registered reads once the table is complete.
module mem_loader #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_eof,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   load_count
);
   typedef enum logic [1:0] {LOAD, PAD, DONE} state_t;
   state_t state, state_next;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic take, store, wr_en, last, in_range;
   assign in_ready  = state == LOAD && !reset;
   assign load_done = state == DONE;
   assign take      = in_valid && in_ready;
   assign store     = take && !in_eof;
   assign last      = wr_ptr == ADDR_WIDTH'(DEPTH - 1);
   assign in_range  = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
   always_comb begin
      wr_en      = store || state == PAD;
      wr_data    = state == PAD ? '0 : in_data;
      state_next = state;
      if (take)
         state_next = in_eof ? PAD : (last ? DONE : LOAD);
      else if (state == PAD && last)
         state_next = DONE;
   end
   always_ff @(posedge clk)
      state <= reset ? LOAD : state_next;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         load_count <= '0;
         data_out   <= '0;
      end else begin
         if (wr_en && !last)
            wr_ptr <= wr_ptr + 1'b1;
         if (store && load_count != (ADDR_WIDTH + 1)'(DEPTH))
            load_count <= load_count + 1'b1;
         if (load_done && enable)
            data_out <= in_range ? mem[address] : '0;
      end
   end
   // no reset on the table: a fresh load rewrites every entry before load_done rises
   always_ff @(posedge clk)
      if (!reset && wr_en)
         mem[wr_ptr] <= wr_data;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized and directed checks of mem_loader against a table model.
module tb_mem_loader;
   localparam int DW = 4, AW = 3, DEPTH = 5;
   logic clk = 0, reset = 1, in_valid = 0, in_eof = 0, enable = 0;
   logic [DW-1:0] in_data = 0;
   logic [AW-1:0] address = 0;
   logic in_ready, load_done;
   logic [DW-1:0] data_out;
   logic [AW:0] load_count;
   int vectors = 0, miscompares = 0;
   logic [DW-1:0] exp_mem [DEPTH];
   int exp_cnt;

   mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
      .in_ready(in_ready), .address(address), .enable(enable), .data_out(data_out),
      .load_done(load_done), .load_count(load_count));

   always #5 clk = ~clk;

   // the loaded table is the first DEPTH file words, zero-filled beyond the file end
   function automatic void model_load(input logic [DW-1:0] words [$]);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = i < words.size() ? words[i] : '0;
      exp_cnt = words.size() < DEPTH ? words.size() : DEPTH;
   endfunction

   function automatic logic [DW-1:0] model_read(input int a);
      return a < DEPTH ? exp_mem[a] : '0;
   endfunction

   task automatic do_reset();
      reset = 1; in_valid = 0; enable = 0;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic eof, input int gap);
      for (int g = 0; g < gap; g++) begin
         in_valid = 0; in_data = DW'($urandom); in_eof = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1; in_data = d; in_eof = eof;
      @(posedge clk); #1;
      in_valid = 0; in_eof = 0;
   endtask

   task automatic do_read(input int a, output logic [DW-1:0] d);
      address = AW'(a); enable = 1;
      @(posedge clk); #1;
      enable = 0;
      d = data_out;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!load_done && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 1; in_data = 4'hA; #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
      vectors++;
      if ({load_done, load_count, data_out} !== '0) begin
         miscompares++; $display("FAIL reset_state got done=%b cnt=%0d dout=%0d want 0/0/0", load_done, load_count, data_out);
      end
      in_valid = 0; reset = 0;
   endtask

   task automatic test_full_load();
      logic [DW-1:0] w [$] = '{4'd3, 4'd7, 4'd1, 4'd9, 4'd4};
      logic [DW-1:0] d;
      do_reset();
      model_load(w);
      for (int i = 0; i < 5; i++) begin
         send(w[i], 0, 0);
         vectors++;
         if (load_done !== (i == 4)) begin miscompares++; $display("FAIL full_done beat%0d got %b want %b", i, load_done, i == 4); end
      end
      vectors++;
      if (load_count !== 4'd5) begin miscompares++; $display("FAIL full_count got %0d want 5", load_count); end
      in_valid = 1; in_eof = 1; #1;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_eof_ready got %b want 0", in_ready); end
      @(posedge clk); #1; in_valid = 0; in_eof = 0;
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== model_read(a)) begin miscompares++; $display("FAIL full_read a=%0d got %0d want %0d", a, d, model_read(a)); end
      end
   endtask

   task automatic test_short();
      logic [DW-1:0] w [$] = '{4'd2, 4'd5};
      logic [DW-1:0] d;
      int n;
      do_reset();
      model_load(w);
      send(2, 0, 0); send(5, 0, 0); send(4'hF, 1, 0);
      wait_done(n);
      vectors++;
      if (n !== 3) begin miscompares++; $display("FAIL short_pad_cycles got %0d want 3", n); end
      vectors++;
      if (load_count !== 4'd2) begin miscompares++; $display("FAIL short_count got %0d want 2", load_count); end
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== model_read(a)) begin miscompares++; $display("FAIL short_read a=%0d got %0d want %0d", a, d, model_read(a)); end
      end
   endtask

   task automatic test_empty();
      logic [DW-1:0] w [$];
      logic [DW-1:0] d;
      int n;
      do_reset();
      model_load(w);
      send(4'h6, 1, 0);
      wait_done(n);
      vectors++;
      if (n !== DEPTH) begin miscompares++; $display("FAIL empty_pad_cycles got %0d want %0d", n, DEPTH); end
      vectors++;
      if (load_count !== 4'd0) begin miscompares++; $display("FAIL empty_count got %0d want 0", load_count); end
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== 4'd0) begin miscompares++; $display("FAIL empty_read a=%0d got %0d want 0", a, d); end
      end
   endtask

   task automatic test_stalls();
      logic [DW-1:0] w [$];
      logic [DW-1:0] d, held;
      do_reset();
      for (int i = 0; i < DEPTH; i++) w.push_back(DW'($urandom_range(1, 15)));
      model_load(w);
      for (int i = 0; i < DEPTH; i++) begin
         enable = i < DEPTH - 1; address = AW'($urandom);
         send(w[i], 0, $urandom_range(1, 3));
         vectors++;
         if (data_out !== 4'd0) begin miscompares++; $display("FAIL stall_dout_in_load beat%0d got %0d want 0", i, data_out); end
      end
      enable = 0;
      do_read(0, d);
      vectors++;
      if (d !== model_read(0)) begin miscompares++; $display("FAIL stall_read0 got %0d want %0d", d, model_read(0)); end
      held = d;
      repeat (3) @(posedge clk); #1;
      vectors++;
      if (data_out !== held) begin miscompares++; $display("FAIL stall_hold got %0d want %0d", data_out, held); end
      do_read(6, d);
      vectors++;
      if (d !== 4'd0) begin miscompares++; $display("FAIL stall_read6 got %0d want 0", d); end
      for (int a = 1; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== model_read(a)) begin miscompares++; $display("FAIL stall_read a=%0d got %0d want %0d", a, d, model_read(a)); end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w [$] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
      logic [DW-1:0] d;
      do_reset();
      repeat (DEPTH) send(4'hF, 0, 0);
      do_read(0, d);
      vectors++;
      if (d !== 4'hF) begin miscompares++; $display("FAIL mid_preload got %0d want 15", d); end
      do_reset();
      vectors++;
      if (data_out !== 4'd0) begin miscompares++; $display("FAIL mid_dout_after_reset got %0d want 0", data_out); end
      repeat (3) send(4'd6, 0, 0);
      do_reset();
      vectors++;
      if ({load_done, load_count} !== '0) begin miscompares++; $display("FAIL mid_abort got done=%b cnt=%0d want 0/0", load_done, load_count); end
      model_load(w);
      foreach (w[i]) send(w[i], 0, 0);
      vectors++;
      if (load_count !== 4'd5 || load_done !== 1'b1) begin miscompares++; $display("FAIL mid_reload got cnt=%0d done=%b want 5/1", load_count, load_done); end
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== 4'd8) begin miscompares++; $display("FAIL mid_read a=%0d got %0d want 8", a, d); end
      end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] w [$];
      logic [DW-1:0] d;
      do_reset();
      send(4'd1, 0, 0); send(4'd1, 1, 0);
      @(posedge clk); #1;
      reset = 1; in_valid = 1; in_data = 4'd9; in_eof = 0;
      @(posedge clk); #1;
      reset = 0; in_valid = 0;
      vectors++;
      if (load_count !== 4'd0) begin miscompares++; $display("FAIL simul_count got %0d want 0", load_count); end
      repeat (DEPTH + 2) @(posedge clk); #1;
      vectors++;
      if (load_done !== 1'b0) begin miscompares++; $display("FAIL simul_pad_aborted got %b want 0", load_done); end
      for (int i = 0; i < DEPTH; i++) w.push_back(DW'($urandom));
      model_load(w);
      foreach (w[i]) send(w[i], 0, 0);
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, d);
         vectors++;
         if (d !== model_read(a)) begin miscompares++; $display("FAIL simul_read a=%0d got %0d want %0d", a, d, model_read(a)); end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] w [$];
      logic [DW-1:0] d;
      int n, nw, a;
      for (int it = 0; it < 20; it++) begin
         w.delete();
         nw = $urandom_range(0, 7);
         for (int i = 0; i < nw; i++) w.push_back(DW'($urandom));
         model_load(w);
         do_reset();
         foreach (w[i]) send(w[i], 0, $urandom_range(0, 2));
         send(DW'($urandom), 1, $urandom_range(0, 2));
         wait_done(n);
         vectors++;
         if (load_done !== 1'b1 || load_count !== (AW + 1)'(exp_cnt)) begin
            miscompares++; $display("FAIL rand_done it=%0d got done=%b cnt=%0d want 1/%0d", it, load_done, load_count, exp_cnt);
         end
         for (int k = 0; k < 8; k++) begin
            a = (k + it) % 8;
            do_read(a, d);
            vectors++;
            if (d !== model_read(a)) begin miscompares++; $display("FAIL rand_read it=%0d a=%0d got %0d want %0d", it, a, d, model_read(a)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_short();
      test_empty();
      test_stalls();
      test_reset_mid();
      test_simultaneous();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
